yc_line_sequencer: RTL and testbench

- Timing controller for the YC (S-Video/composite) chroma modulator running on the 50 MHz subcarrier-sample clock.
- Validates hsync pulses and sequences each line through sync, breezeway, colour burst, back porch and active chroma.
- Drives the modulator's burst gate, chroma gate, sin/cos LUT index and per-line burst/chroma phase inversion.
- Suppresses burst during vsync and recovers from lost sync via a watchdog.

---
 rtl/yc_line_sequencer.sv | 136 +++++++++++++
 tb/tb_yc_line_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/yc_line_sequencer.sv
// rtl/yc_line_sequencer.sv - YC chroma modulator line timing sequencer
// Validates hsync, walks each line through sync/breezeway/burst/porch/active, drives modulator gates.
module yc_line_sequencer #(
  parameter int LUT_LEN      = 14,
  parameter int MIN_SYNC     = 8,
  parameter int BURST_START  = 20,
  parameter int BURST_LEN    = 136,
  parameter int ACTIVE_START = 156,
  parameter int LINE_TIMEOUT = 4095,
  parameter int PHASE_ALT    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  output logic       burst_en,
  output logic       chroma_en,
  output logic [4:0] lut_idx,
  output logic       phase_inv,
  output logic [9:0] line_cnt,
  output logic       sync_err
);

  localparam int SLEN_W = $clog2(MIN_SYNC + 1);
  localparam logic [SLEN_W-1:0] SLEN_MAX = SLEN_W'(MIN_SYNC);
  localparam logic [11:0] BURST_FIRST  = 12'(BURST_START - 1);
  localparam logic [11:0] BURST_LAST   = 12'(BURST_START + BURST_LEN - 1);
  localparam logic [11:0] ACTIVE_FIRST = 12'(ACTIVE_START - 1);
  localparam logic [11:0] TIMEOUT      = 12'(LINE_TIMEOUT);
  localparam logic [4:0]  LUT_LAST     = 5'(LUT_LEN - 1);
  localparam bit          HAS_PORCH    = (ACTIVE_START > BURST_START + BURST_LEN);

  typedef enum logic [2:0] {IDLE, SYNC, BREEZE, BURST, PORCH, ACTIVE} state_t;

  state_t              state, next_state, prev_state;
  logic                vsync_d;
  logic [SLEN_W-1:0]   slen;
  logic [11:0]         pos;
  logic                accept, reject, timeout, slen_load;
  logic                vsync_rise;

  assign vsync_rise = vsync && !vsync_d;

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    reject     = 1'b0;
    timeout    = 1'b0;
    slen_load  = 1'b0;
    case (state)
      IDLE: begin
        if (hsync) begin
          next_state = SYNC;
          slen_load  = 1'b1;
        end
      end
      SYNC: begin
        if (!hsync) begin
          if (slen >= SLEN_MAX) begin
            next_state = BREEZE;
            accept     = 1'b1;
          end else begin
            // prev_state is IDLE when no line was running, so a glitch there just falls back
            next_state = prev_state;
            reject     = 1'b1;
          end
        end
      end
      default: begin
        if (hsync) begin
          next_state = SYNC;
          slen_load  = 1'b1;
        end else if (pos >= TIMEOUT) begin
          next_state = IDLE;
          timeout    = 1'b1;
        end else begin
          // >= rather than == so a line resumed after a rejected glitch cannot skip a boundary
          case (state)
            BREEZE: if (pos >= BURST_FIRST) next_state = BURST;
            BURST:  if (pos >= BURST_LAST)  next_state = HAS_PORCH ? PORCH : ACTIVE;
            PORCH:  if (pos >= ACTIVE_FIRST) next_state = ACTIVE;
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      prev_state <= IDLE;
      vsync_d    <= 1'b0;
      slen       <= '0;
      pos        <= '0;
      lut_idx    <= '0;
      burst_en   <= 1'b0;
      chroma_en  <= 1'b0;
      phase_inv  <= 1'b0;
      line_cnt   <= '0;
      sync_err   <= 1'b0;
    end else begin
      state   <= next_state;
      vsync_d <= vsync;
      // subcarrier phase never resyncs to hsync
      lut_idx <= (lut_idx == LUT_LAST) ? 5'd0 : lut_idx + 5'd1;

      if (slen_load)
        slen <= {{(SLEN_W-1){1'b0}}, 1'b1};
      else if (state == SYNC && hsync && slen < SLEN_MAX)
        slen <= slen + 1'b1;

      if (state != SYNC && next_state == SYNC)
        prev_state <= state;

      if (accept)
        pos <= '0;
      else if (state != IDLE && pos != 12'hFFF)
        pos <= pos + 12'd1;

      if (vsync_rise) begin
        line_cnt  <= '0;
        phase_inv <= 1'b0;
      end else if (accept) begin
        if (line_cnt != 10'd1023)
          line_cnt <= line_cnt + 10'd1;
        phase_inv <= (PHASE_ALT != 0) ? ~phase_inv : 1'b0;
      end

      burst_en  <= (next_state == BURST) && !vsync;
      chroma_en <= (next_state == ACTIVE) && !vsync;
      sync_err  <= reject || timeout;
    end
  end

endmodule

// File: tb/tb_yc_line_sequencer.sv
// tb/tb_yc_line_sequencer.sv - scoreboard bench for yc_line_sequencer
// Directed line sequences; expected values queued at stimulus time and popped at observation.
module tb_yc_line_sequencer;

  logic       clk, reset, hsync, vsync;
  logic       burst_en, chroma_en, phase_inv, sync_err;
  logic [4:0] lut_idx;
  logic [9:0] line_cnt;
  logic       np_burst, np_chroma, np_phase, np_err;
  logic [4:0] np_lut;
  logic [9:0] np_line_cnt;

  int total = 0;
  int bad   = 0;
  int tick  = 0;
  int cyc;
  int fall1, fall2;
  logic [31:0] n;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;
  sb_t sb[$];

  yc_line_sequencer u_dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .burst_en(burst_en), .chroma_en(chroma_en), .lut_idx(lut_idx),
    .phase_inv(phase_inv), .line_cnt(line_cnt), .sync_err(sync_err)
  );

  yc_line_sequencer #(.PHASE_ALT(0)) u_np (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .burst_en(np_burst), .chroma_en(np_chroma), .lut_idx(np_lut),
    .phase_inv(np_phase), .line_cnt(np_line_cnt), .sync_err(np_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference subcarrier counter: clocks since last reset release
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic step();
    @(negedge clk);
    tick++;
  endtask

  task automatic exp_push(input string tag, input logic [31:0] val);
    sb.push_back('{tag, val});
  endtask

  task automatic got(input string tag, input logic [31:0] obs);
    sb_t e;
    e = '{"<empty>", 32'hDEAD_BEEF};
    if (sb.size() > 0) e = sb.pop_front();
    total++;
    assert (e.tag == tag && obs === e.val)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d (queued %s)", tag, obs, e.val, e.tag);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return burst_en;
      1: return chroma_en;
      2: return sync_err;
      3: return burst_en | chroma_en;
      default: return burst_en | chroma_en | sync_err;
    endcase
  endfunction

  task automatic wait_high(input int which, input int limit, output logic [31:0] cnt);
    bit found;
    found = 1'b0;
    cnt = '1;
    for (int i = 1; i <= limit && !found; i++) begin
      step();
      if (sig(which)) begin
        cnt = i;
        found = 1'b1;
      end
    end
  endtask

  task automatic count_high(input int which, input int limit, output logic [31:0] cnt);
    cnt = 0;
    while (sig(which) && cnt < limit) begin
      cnt++;
      step();
    end
  endtask

  task automatic count_pulses(input int which, input int cycles, output logic [31:0] cnt);
    cnt = 0;
    repeat (cycles) begin
      step();
      if (sig(which)) cnt++;
    end
  endtask

  task automatic pulse(input int w);
    hsync = 1'b1;
    repeat (w) step();
    hsync = 1'b0;
  endtask

  initial begin
    reset = 1'b0; hsync = 1'b0; vsync = 1'b0;
    #2 reset = 1'b1;
    repeat (3) step();
    exp_push("rst_outs", 0);
    got("rst_outs", {burst_en, chroma_en, lut_idx, phase_inv, line_cnt, sync_err});
    reset = 1'b0;

    // line 1
    repeat (5) step();
    exp_push("l1_burst_delay", 21); exp_push("l1_burst_len", 136);
    exp_push("l1_chroma_next", 1);  exp_push("l1_line_cnt", 1);
    exp_push("l1_phase", 1);        exp_push("np_phase", 0);
    exp_push("np_state", {1'b0, 1'b1, 1'b0}); exp_push("np_lut", cyc % 14 + 0);
    pulse(10);
    fall1 = tick;
    wait_high(0, 100, n);         got("l1_burst_delay", n);
    count_high(0, 300, n);        got("l1_burst_len", n);
    got("l1_chroma_next", chroma_en);
    got("l1_line_cnt", line_cnt);
    got("l1_phase", phase_inv);
    got("np_phase", np_phase);
    got("np_state", {np_burst, np_chroma, np_err});
    sb.delete(sb.size() - 1);
    exp_push("np_lut", cyc % 14);
    got("np_lut", np_lut);

    // line 2, 3178 clocks after line 1
    repeat (fall1 + 3178 - 10 - tick) step();
    exp_push("l2_chroma_pre", 1);
    got("l2_chroma_pre", chroma_en);
    hsync = 1'b1;
    step();
    exp_push("l2_chroma_drop", 0);
    got("l2_chroma_drop", chroma_en);
    repeat (9) step();
    hsync = 1'b0;
    fall2 = tick;
    exp_push("l2_spacing", 3178);
    got("l2_spacing", fall2 - fall1);
    exp_push("l2_burst_delay", 21);
    wait_high(0, 100, n);         got("l2_burst_delay", n);
    exp_push("l2_lut", cyc % 14); got("l2_lut", lut_idx);
    exp_push("l2_line_cnt", 2);   got("l2_line_cnt", line_cnt);
    exp_push("l2_phase", 0);      got("l2_phase", phase_inv);
    exp_push("l2_np_phase", 0);   got("l2_np_phase", np_phase);
    exp_push("l2_chroma_rise", 136);
    wait_high(1, 400, n);         got("l2_chroma_rise", n);

    // 3-clock glitch in ACTIVE
    repeat (100) step();
    exp_push("gl_chroma_off", 0); exp_push("gl_err_pulses", 1);
    exp_push("gl_chroma_back", 1); exp_push("gl_line_cnt", 2);
    hsync = 1'b1;
    step();
    got("gl_chroma_off", chroma_en);
    step(); step();
    hsync = 1'b0;
    count_pulses(2, 8, n);        got("gl_err_pulses", n);
    got("gl_chroma_back", chroma_en);
    got("gl_line_cnt", line_cnt);

    // watchdog timeout
    exp_push("to_delay", 4097); exp_push("to_chroma", 0); exp_push("to_err_one", 0);
    wait_high(2, 5000, n);
    got("to_delay", tick - fall2);
    got("to_chroma", chroma_en);
    step();
    got("to_err_one", sync_err);

    // line 3 after timeout
    repeat (20) step();
    exp_push("l3_burst_delay", 21); exp_push("l3_line_cnt", 3); exp_push("l3_phase", 1);
    pulse(10);
    wait_high(0, 100, n);         got("l3_burst_delay", n);
    got("l3_line_cnt", line_cnt);
    got("l3_phase", phase_inv);

    // vsync across line 4
    exp_push("vs_line_cnt", 0); exp_push("vs_phase", 0); exp_push("vs_burst", 0);
    vsync = 1'b1;
    step();
    got("vs_line_cnt", line_cnt);
    got("vs_phase", phase_inv);
    got("vs_burst", burst_en);
    repeat (200) step();
    exp_push("vs_gates", 0); exp_push("vs_l4_cnt", 1); exp_push("vs_l4_phase", 1);
    pulse(10);
    count_pulses(3, 400, n);      got("vs_gates", n);
    got("vs_l4_cnt", line_cnt);
    got("vs_l4_phase", phase_inv);
    vsync = 1'b0;
    repeat (20) step();

    // vsync rise coinciding with an accepted line start
    exp_push("co_line_cnt", 0); exp_push("co_phase", 0);
    hsync = 1'b1;
    repeat (10) step();
    hsync = 1'b0;
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    got("co_line_cnt", line_cnt);
    got("co_phase", phase_inv);
    repeat (30) step();

    // reset during BURST
    exp_push("l6_burst_delay", 21); exp_push("l6_line_cnt", 1); exp_push("l6_phase", 1);
    exp_push("rb_outs", 0);
    pulse(10);
    wait_high(0, 100, n);         got("l6_burst_delay", n);
    got("l6_line_cnt", line_cnt);
    got("l6_phase", phase_inv);
    repeat (5) step();
    reset = 1'b1;
    #1;
    got("rb_outs", {burst_en, chroma_en, phase_inv, line_cnt});
    step();
    reset = 1'b0;
    exp_push("rb_idle", 0);
    count_pulses(4, 60, n);       got("rb_idle", n);
    exp_push("rb_lut", cyc % 14); got("rb_lut", lut_idx);

    // glitch while IDLE
    exp_push("ig_err", 1); exp_push("ig_gates", 0);
    pulse(3);
    count_pulses(2, 6, n);        got("ig_err", n);
    count_pulses(3, 300, n);      got("ig_gates", n);

    // clean restart
    exp_push("l7_burst_delay", 21); exp_push("l7_burst_len", 136); exp_push("l7_line_cnt", 1);
    pulse(10);
    wait_high(0, 100, n);         got("l7_burst_delay", n);
    count_high(0, 300, n);        got("l7_burst_len", n);
    got("l7_line_cnt", line_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
